// File: rtl/wide_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer_pkg
//  Description : Shared types and constants for the wide-operand sequencer
//                that drives the registered 4-bit adder one nibble at a time.
//  Revision    : 1.0  initial release
// ============================================================================
package wide_add_sequencer_pkg;

    // Width of one adder slice.
    localparam int NIBBLE_W = 4;

    // Latency of the registered adder (input and output registers).
    localparam int DEFAULT_ADD_LAT = 2;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        OUTPUT  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_sequencer
//  Description : Accepts a wide operand pair, feeds the external registered
//                4-bit adder nibble by nibble (LSB first) with carry chained
//                through, collects the sum nibbles and returns the full sum
//                and final carry over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int ADD_LAT = DEFAULT_ADD_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
    input  logic                          in_cin,
    output logic [NIBBLE_W-1:0]           add_a,
    output logic [NIBBLE_W-1:0]           add_b,
    output logic                          add_cin,
    input  logic [NIBBLE_W-1:0]           add_s,
    input  logic                          add_cout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_sum,
    output logic                          out_cout,
    output logic                          busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] c_wait_init = CNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] c_wait_one  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [W-1:0]       r_out_sum;
    logic               r_out_cout;
    logic [W-1:0]       w_sum_merged;
    logic               w_last;

    assign w_last = (r_idx == c_last_idx);

    // Partial sum with the adder's current nibble dropped into its slot.
    always_comb begin
        w_sum_merged = r_sum;
        w_sum_merged[r_idx*NIBBLE_W +: NIBBLE_W] = add_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_next = ISSUE;
            ISSUE:   w_state_next = (ADD_LAT == 1) ? CAPTURE : WAIT;
            WAIT:    if (r_wait_cnt == c_wait_one) w_state_next = CAPTURE;
            CAPTURE: w_state_next = w_last ? OUTPUT : ISSUE;
            OUTPUT:  if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decode from state and registers only, so no input reaches an
    // output combinationally.
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == OUTPUT);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (r_state == ISSUE) begin
            add_a   = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
            add_b   = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
            add_cin = r_carry;
        end
    end

    // Operand latch, latency counter, nibble index and result collection.
    // The output registers load only on the final capture so out_sum and
    // out_cout keep their last value once the handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= c_wait_init;
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - c_wait_one;
                end
                CAPTURE: begin
                    r_sum   <= w_sum_merged;
                    r_carry <= add_cout;
                    if (w_last) begin
                        r_out_sum  <= w_sum_merged;
                        r_out_cout <= add_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum  = r_out_sum;
    assign out_cout = r_out_cout;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_sequencer
//  Description : Self-checking bench for wide_add_sequencer with a registered
//                4-bit adder beside it and an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wide_add_sequencer;

    localparam int N   = 4;
    localparam int L   = 2;
    localparam int W   = 4 * N;
    localparam int LAT = N * (L + 1) + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.NIBBLES(N), .ADD_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Registered 4-bit adder: input registers then output registers, sharing rst.
    logic [3:0] adder_a_q, adder_b_q;
    logic       adder_c_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_a_q <= '0;
            adder_b_q <= '0;
            adder_c_q <= 1'b0;
            add_s     <= '0;
            add_cout  <= 1'b0;
        end else begin
            adder_a_q <= add_a;
            adder_b_q <= add_b;
            adder_c_q <= add_cin;
            {add_cout, add_s} <= {1'b0, adder_a_q} + {1'b0, adder_b_q} + {4'd0, adder_c_q};
        end
    end

    // Reference: full (W+1)-bit sum.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Reference: carry entering nibble k = carry out of the low k nibbles.
    function automatic logic ref_carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input int k);
        logic [W:0] m;
        logic [W:0] s;
        m = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
        return s[4 * k];
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] v, input int k);
        return 4'(v >> (4 * k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one operand pair for one cycle.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Follows one transaction from the cycle after accept up to out_valid,
    // checking adder drive at each issue slot, latency and the result.
    task automatic walk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit chk_issue);
        int         c;
        int         k;
        logic [W:0] exp;
        exp = ref_sum(a, b, cin);
        c = 1;
        while (out_valid !== 1'b1 && c < LAT + 50) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_in_ready cycle %0d: in_ready=%b required 0", c, in_ready);
            end
            if (chk_issue && c <= N * (L + 1) && ((c - 1) % (L + 1)) == 0) begin
                k = (c - 1) / (L + 1);
                n_checks++;
                if ({add_a, add_b, add_cin} !== {nib(a, k), nib(b, k), ref_carry_into(a, b, cin, k)}) begin
                    n_errors++;
                    $display("FAIL issue nibble %0d: a=%h b=%h cin=%b required a=%h b=%h cin=%b",
                             k, add_a, add_b, add_cin, nib(a, k), nib(b, k),
                             ref_carry_into(a, b, cin, k));
                end
            end
            tick();
            c++;
        end
        n_checks++;
        if (c !== LAT || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL latency: out_valid=%b at cycle %0d required rise at cycle %0d",
                     out_valid, c, LAT);
        end
        n_checks++;
        if ({out_cout, out_sum} !== exp) begin
            n_errors++;
            $display("FAIL result %h+%h+%b: got cout=%b sum=%h required cout=%b sum=%h",
                     a, b, cin, out_cout, out_sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        out_ready = 1'b1;
        accept(a, b, cin);
        walk(a, b, cin, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_errors++;
            $display("FAIL return_idle: valid/ready/busy=%b%b%b required 010",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_cout} !== 4'b1000 || out_sum !== '0) begin
            n_errors++;
            $display("FAIL reset_flags: ready/valid/busy/cout=%b%b%b%b sum=%h required 1000 0000",
                     in_ready, out_valid, busy, out_cout, out_sum);
        end
        n_checks++;
        if ({add_a, add_b, add_cin} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_adder_drive: %h %h %b required zeros", add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_one(16'h1234, 16'h1111, 1'b0);
        run_one(16'hFFFF, 16'h0001, 1'b0);
        run_one(16'h0000, 16'h0000, 1'b1);
        run_one(16'h8000, 16'h8000, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [W:0] exp;
        exp = ref_sum(16'hABCD, 16'h1357, 1'b1);
        out_ready = 1'b0;
        accept(16'hABCD, 16'h1357, 1'b1);
        walk(16'hABCD, 16'h1357, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom);
            tick();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || {out_cout, out_sum} !== exp) begin
                n_errors++;
                $display("FAIL backpressure hold %0d: valid=%b ready=%b cout=%b sum=%h required 1 0 %b %h",
                         i, out_valid, in_ready, out_cout, out_sum, exp[W], exp[W-1:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_errors++;
            $display("FAIL backpressure release: valid/ready/busy=%b%b%b required 010",
                     out_valid, in_ready, busy);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure ignored_input: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        accept(16'h1234, 16'h5678, 1'b0);
        // Now in cycle 1; advance to cycle 2*(L+1)+2, the WAIT of nibble 2.
        repeat (2 * (L + 1) + 1) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_errors++;
            $display("FAIL reset_mid: valid/ready/busy=%b%b%b required 010",
                     out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_one(16'h00FF, 16'h0001, 1'b0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_a      = 16'h4321;
        in_b      = 16'h0F0F;
        in_cin    = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_a   = 16'hC3A5;
        in_b   = 16'h5A5A;
        in_cin = 1'b0;
        walk(16'h4321, 16'h0F0F, 1'b1, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL b2b idle_gap: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        walk(16'hC3A5, 16'h5A5A, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_errors++;
            $display("FAIL b2b end: valid/ready/busy=%b%b%b required 010",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   exp;
        int           hold;
        for (int i = 0; i < 10; i++) begin
            a    = W'($urandom);
            b    = W'($urandom);
            cin  = 1'($urandom);
            hold = int'($urandom_range(0, 3));
            exp  = ref_sum(a, b, cin);
            out_ready = (hold == 0);
            accept(a, b, cin);
            walk(a, b, cin, 1'b1);
            for (int h = 0; h < hold; h++) begin
                tick();
                n_checks++;
                if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp) begin
                    n_errors++;
                    $display("FAIL random %0d hold: valid=%b cout=%b sum=%h required 1 %b %h",
                             i, out_valid, out_cout, out_sum, exp[W], exp[W-1:0]);
                end
            end
            out_ready = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL random %0d drop: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Operand sequencer placed both upstream and downstream of the team's registered 4-bit adder (input and output pipeline registers, 2-cycle latency).
- Accepts a wide operand pair (4*NIBBLES bits) over a valid/ready handshake.
- Feeds the adder one nibble at a time, least-significant first, chaining carry-out back as the next carry-in.
- Collects the sum nibbles and returns the full-width sum and carry over a second valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES. Must be >= 1.
- ADD_LAT, 2, cycles from driving add_a/add_b/add_cin to a valid add_s/add_cout. Must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in for the least-significant nibble.
- add_a  out  4  nibble of A driven to the adder.
- add_b  out  4  nibble of B driven to the adder.
- add_cin  out  1  carry-in driven to the adder.
- add_s  in  4  adder sum output.
- add_cout  in  1  adder carry output.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  full-width sum.
- out_cout  out  1  final carry-out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE, ISSUE, WAIT, CAPTURE, OUTPUT. Registers: a_q, b_q, sum_q, carry_q, idx (clog2(NIBBLES) bits, minimum 1), wait_cnt.
- Reset (asynchronous, takes effect immediately): state=IDLE, all registers 0, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, add_a/add_b/add_cin=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_q=in_a, b_q=in_b, carry_q=in_cin, idx=0, sum_q=0; next state ISSUE.
- ISSUE (1 cycle):
  - add_a=a_q[4*idx+:4], add_b=b_q[4*idx+:4], add_cin=carry_q.
  - wait_cnt=ADD_LAT-1.
  - Next state WAIT, or CAPTURE directly if ADD_LAT==1.
- Outside ISSUE, add_a/add_b/add_cin=0.
- add_* outputs decode from state and registers only; no combinational path from any input to any output.
- WAIT:
  - Decrement wait_cnt each cycle.
  - Go to CAPTURE when wait_cnt reaches 1 (i.e. ADD_LAT-1 cycles spent in WAIT).
- CAPTURE:
  - sum_q[4*idx+:4]=add_s, carry_q=add_cout.
  - If idx==NIBBLES-1, next state OUTPUT; otherwise idx+1 and next state ISSUE.
- OUTPUT:
  - out_valid=1; out_sum=sum_q, out_cout=carry_q, both held stable while out_valid && !out_ready.
  - On out_ready, next state IDLE and out_valid drops the following cycle.
- Outside OUTPUT, out_valid=0 and out_sum/out_cout hold their last value.
- Timing:
  - Per-nibble cost is ADD_LAT+1 cycles.
  - With the accept cycle as cycle 0, out_valid first rises in cycle NIBBLES*(ADD_LAT+1)+1. This is cycle 13 with the defaults.
- in_valid outside IDLE is ignored (in_ready=0); operands are not re-sampled mid-operation.
- Arithmetic: out_sum and out_cout together equal the (W+1)-bit value in_a + in_b + in_cin. Wrap of out_sum is modulo 2^W, with the overflow carried in out_cout.
- Reset mid-operation abandons the transaction and no result is emitted. The adder shares rst, so its pipeline is also cleared; no stale add_s is captured afterwards.
- One transaction is in flight at a time. There is no overlap between the OUTPUT handshake and a new accept; the earliest new accept is the cycle after returning to IDLE.

Decomposition:
- Shared package:
  - state enum (IDLE, ISSUE, WAIT, CAPTURE, OUTPUT);
  - localparam NIBBLE_W=4;
  - default ADD_LAT=2, matching the adder latency.
- No sub-module; single FSM plus datapath.
- The 4-bit adder is instantiated beside this block at the next level up, connected via the add_* ports. Its clk/rst are tied to the same nets.

Test Plan:
- in_a=0x1234, in_b=0x1111, in_cin=0, out_ready=1 -> out_sum=0x2345, out_cout=0; out_valid rises in cycle 13 after accept; add_cin=0 at every ISSUE.
- in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1; add_cin=0,1,1,1 on successive ISSUE cycles.
- in_a=0x0000, in_b=0x0000, in_cin=1 -> out_sum=0x0001, out_cout=0; in_a=0x8000, in_b=0x8000, in_cin=0 -> out_sum=0x0000, out_cout=1.
- Backpressure: out_ready=0 for 5 cycles during OUTPUT -> out_valid, out_sum and out_cout stable; in_ready=0; in_valid with new operands is ignored. After release, return to IDLE and in_ready=1.
- Reset during WAIT of nibble 2 -> immediately out_valid=0, in_ready=1, busy=0. A subsequent 0x00FF+0x0001 gives 0x0100, out_cout=0, with correct latency.
- Back-to-back: two transactions with in_valid held high and out_ready=1 -> both results correct, in order, and each accept occurs only in IDLE.
